rotl_seq: RTL and testbench

- Sequential 16-bit left-shift/rotate engine. It is the opposite-direction companion to the combinational 1-bit right-rotate unit in the Blue datapath.
- Accepts a word and a shift amount (0–15) and performs one bit-position left step per clock.
- Presents the result with a carry-out bit under a valid/ready output handshake.
- Used by the beamformer control path where a programmable left rotate/shift is needed and area matters more than latency.

---
 rtl/rotl_seq.sv | 102 ++++++++++
 tb/tb_rotl_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rotl_seq.sv
// rtl/rotl_seq.sv - sequential left rotate/shift engine, one bit step per clock
module rotl_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [CNT_W-1:0] amount,
  input  logic             mode,
  output logic             busy,
  output logic [WIDTH-1:0] A_out,
  output logic             carry_out,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             mode_r;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (cnt == '0) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Working register: latch on accept, one left step per SHIFT cycle until
  // the count is exhausted, then frozen while the result is presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      A_out     <= '0;
      carry_out <= 1'b0;
      cnt       <= '0;
      mode_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            A_out     <= A_in;
            cnt       <= amount;
            mode_r    <= mode;
            carry_out <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (cnt != '0) begin
            carry_out <= A_out[WIDTH-1];
            A_out     <= {A_out[WIDTH-2:0], mode_r ? 1'b0 : A_out[WIDTH-1]};
            cnt       <= cnt - CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotl_seq.sv
// tb/tb_rotl_seq.sv - directed self-checking bench for rotl_seq
module tb_rotl_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] A_in;
  logic [3:0]  amount;
  logic        mode;
  logic        busy;
  logic [15:0] A_out;
  logic        carry_out;
  logic        out_valid;
  logic        out_ready;

  int tests_run;
  int tests_failed;

  rotl_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .A_in      (A_in),
    .amount    (amount),
    .mode      (mode),
    .busy      (busy),
    .A_out     (A_out),
    .carry_out (carry_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then leave start low.
  task automatic accept(input logic [15:0] a, input logic [3:0] amt, input logic m);
    A_in   = a;
    amount = amt;
    mode   = m;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    A_in   = 16'h0000;
    amount = 4'd0;
    mode   = ~m;
  endtask

  // Wait (bounded) for out_valid after an accept, returning edges elapsed.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [3:0] amt,
                        input logic m, input logic [15:0] exp_a, input logic exp_c);
    int lat;
    accept(a, amt, m);
    check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
    wait_valid(lat);
    check({tag, "_latency"}, lat, amt + 32'd1);
    check({tag, "_a_out"}, {16'd0, A_out}, {16'd0, exp_a});
    check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
    check({tag, "_busy_hold"}, {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    A_in      = 16'h0;
    amount    = 4'd0;
    mode      = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_out", {16'd0, A_out}, 32'd0);
    check("rst_carry", {31'd0, carry_out}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Rotate and logical-shift vectors.
    run_op("rot8001_1", 16'h8001, 4'd1, 1'b0, 16'h0003, 1'b1);
    run_op("rot1234_4", 16'h1234, 4'd4, 1'b0, 16'h2341, 1'b1);
    run_op("shlF00F_4", 16'hF00F, 4'd4, 1'b1, 16'h00F0, 1'b1);
    // Last bit out on the 15th step is original bit 1 of 0xF00F, a one.
    run_op("shlF00F_15", 16'hF00F, 4'd15, 1'b1, 16'h8000, 1'b1);
    run_op("rotABCD_0", 16'hABCD, 4'd0, 1'b0, 16'hABCD, 1'b0);
    run_op("shl0001_15", 16'h0001, 4'd15, 1'b1, 16'h8000, 1'b0);

    // Backpressure: rotate 0x0001 by 15, then stall with start pulses.
    begin
      int lat;
      accept(16'h0001, 4'd15, 1'b0);
      wait_valid(lat);
      check("bp_latency", lat, 32'd16);
      check("bp_a_out", {16'd0, A_out}, 32'h8000);
      check("bp_carry", {31'd0, carry_out}, 32'd0);
      for (int i = 0; i < 5; i++) begin
        A_in   = 16'hFFFF;
        amount = 4'd3;
        mode   = 1'b0;
        start  = (i % 2 == 0);
        @(posedge clk);
        #1;
        check("bp_stall_a_out", {16'd0, A_out}, 32'h8000);
        check("bp_stall_valid", {31'd0, out_valid}, 32'd1);
      end
      // start alongside out_ready in HOLD must not be taken.
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      out_ready = 1'b0;
      check("bp_exit_busy", {31'd0, busy}, 32'd0);
      check("bp_exit_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      check("bp_idle_stays", {31'd0, busy}, 32'd0);
      run_op("bp_next", 16'hFFFF, 4'd0, 1'b0, 16'hFFFF, 1'b0);
    end

    // out_ready in IDLE does nothing.
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_ready_valid", {31'd0, out_valid}, 32'd0);

    // Reset during the 4th SHIFT cycle of a 10-step rotate.
    accept(16'h5555, 4'd10, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_a_out", {16'd0, A_out}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_carry", {31'd0, carry_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_idle", {31'd0, busy}, 32'd0);
    run_op("rot5555_1", 16'h5555, 4'd1, 1'b0, 16'hAAAA, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
